// File: rtl/uart_alu_sequencer_pkg.sv
// Shared state encodings, status codes and frame constants
// for the UART command/ALU sequencer.
package uart_alu_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_OP,
        S_GET_A,
        S_GET_B,
        S_GET_CHK,
        S_EXEC,
        S_RESP,
        S_TXWAIT
    } state_t;

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'h01;
    localparam logic [7:0] ST_OP  = 8'h02;
    localparam logic [7:0] ST_TMO = 8'h03;

    localparam logic [7:0] SOF_CMD_DEF = 8'hA5;
    localparam logic [7:0] SOF_RSP_DEF = 8'h5A;

    function automatic logic [7:0] rsp_byte(
        input logic [1:0] idx,
        input logic [7:0] sof,
        input logic [7:0] status,
        input logic [7:0] result
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = sof;
            2'd1:    b = status;
            2'd2:    b = result;
            default: b = status ^ result;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts while enabled, clears on every byte,
// pulses expire on the cycle the count reaches TIMEOUT-1.
module uart_gap_timer #(
    parameter int TIMEOUT = 434000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);

    logic [19:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

    // A byte arriving on the expiry cycle takes precedence
    assign expire = en && !clear && (cnt == 20'(TIMEOUT - 1));

endmodule

// File: rtl/uart_alu_sequencer.sv
// Framed command controller: collects a 5-byte command from RX,
// drives the ALU and returns a 4-byte response through TX.
module uart_alu_sequencer
    import uart_alu_sequencer_pkg::*;
#(
    parameter int         OP_W    = 6,
    parameter int         ALU_LAT = 1,
    parameter int         TIMEOUT = 434000,
    parameter logic [7:0] SOF_CMD = SOF_CMD_DEF,
    parameter logic [7:0] SOF_RSP = SOF_RSP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    input  logic            tx_done,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic [7:0]      A,
    output logic [7:0]      B,
    output logic [OP_W-1:0] opcode,
    input  logic [7:0]      alu_result,
    output logic            busy,
    output logic            rx_dropped
);

    localparam int LW = $clog2(ALU_LAT + 1);

    state_t state, next;

    logic [7:0]    op_q, a_q, b_q;
    logic [7:0]    status, result;
    logic [1:0]    idx;
    logic [LW-1:0] exec_cnt;
    logic          in_get, expire, exec_done, chk_bad, op_bad;

    assign in_get    = state inside {S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK};
    assign exec_done = exec_cnt == LW'(ALU_LAT);
    assign chk_bad   = rx_data != (op_q ^ a_q ^ b_q);
    assign op_bad    = (op_q >> OP_W) != 8'd0;

    uart_gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_gap (
        .clk   (clk),
        .reset (reset),
        .clear (rx_done),
        .en    (in_get),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:    if (rx_done && rx_data == SOF_CMD) next = S_GET_OP;
            S_GET_OP:  if (rx_done) next = S_GET_A;
                       else if (expire) next = S_RESP;
            S_GET_A:   if (rx_done) next = S_GET_B;
                       else if (expire) next = S_RESP;
            S_GET_B:   if (rx_done) next = S_GET_CHK;
                       else if (expire) next = S_RESP;
            S_GET_CHK: if (rx_done) next = (chk_bad || op_bad) ? S_RESP : S_EXEC;
                       else if (expire) next = S_RESP;
            S_EXEC:    if (exec_done) next = S_RESP;
            S_RESP:    next = S_TXWAIT;
            S_TXWAIT:  if (tx_done) next = (idx == 2'd3) ? S_IDLE : S_RESP;
            default:   next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_start   = state == S_RESP;
        busy       = state != S_IDLE;
        rx_dropped = rx_done && (state inside {S_EXEC, S_RESP, S_TXWAIT});
        tx_data    = '0;
        if (state == S_RESP || state == S_TXWAIT)
            tx_data = rsp_byte(idx, SOF_RSP, status, result);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            status   <= '0;
            result   <= '0;
            idx      <= '0;
            exec_cnt <= '0;
            A        <= '0;
            B        <= '0;
            opcode   <= '0;
        end else begin
            if (rx_done && state == S_GET_OP) op_q <= rx_data;
            if (rx_done && state == S_GET_A)  a_q  <= rx_data;
            if (rx_done && state == S_GET_B)  b_q  <= rx_data;
            if (in_get && expire) begin
                status <= ST_TMO;
                result <= '0;
            end
            if (rx_done && state == S_GET_CHK) begin
                status <= chk_bad ? ST_CHK : (op_bad ? ST_OP : ST_OK);
                result <= '0;
            end
            // Operands only change when a validated frame enters execution
            if (state == S_GET_CHK && next == S_EXEC) begin
                A      <= a_q;
                B      <= b_q;
                opcode <= op_q[OP_W-1:0];
            end
            exec_cnt <= (state == S_EXEC) ? exec_cnt + LW'(1) : '0;
            if (state == S_EXEC && exec_done) result <= alu_result;
            if (state == S_IDLE)
                idx <= '0;
            else if (state == S_TXWAIT && tx_done)
                idx <= idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomized self-checking bench for uart_alu_sequencer with an
// A+B ALU and a frame-level response model.
module tb_uart_alu_sequencer;

    localparam int OP_W    = 6;
    localparam int ALU_LAT = 1;
    localparam int TMO     = 40;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      rx_data = '0;
    logic            rx_done = 1'b0;
    logic            tx_done = 1'b0;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic [7:0]      A, B;
    logic [OP_W-1:0] opcode;
    logic [7:0]      alu_result;
    logic            busy, rx_dropped;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0]      m_a = '0;
    logic [7:0]      m_b = '0;
    logic [OP_W-1:0] m_op = '0;

    uart_alu_sequencer #(
        .OP_W(OP_W), .ALU_LAT(ALU_LAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .A(A), .B(B), .opcode(opcode), .alu_result(alu_result),
        .busy(busy), .rx_dropped(rx_dropped)
    );

    assign alu_result = A + B;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Frame-level reference: response word {SOF, status, result, xor}
    function automatic logic [31:0] model(
        input logic [7:0] op, a, b, chk, input bit tmo, output bit ok
    );
        logic [7:0] st, res;
        if (tmo)                      st = 8'd3;
        else if (chk != (op ^ a ^ b)) st = 8'd1;
        else if (op >= (1 << OP_W))   st = 8'd2;
        else                          st = 8'd0;
        ok  = (st == 8'd0);
        res = ok ? 8'(a + b) : 8'd0;
        return {8'h5A, st, res, st ^ res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, a, b, chk, output int t0);
        send_byte(8'hA5);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(op);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(a);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(b);
        repeat ($urandom_range(0, 2)) tick();
        t0 = cyc;
        send_byte(chk);
    endtask

    task automatic collect(
        input int n, input int budget, input int drop_at,
        output logic [31:0] rsp, output int got, output int viol,
        output int first_cyc, output bit dropped
    );
        logic [7:0] d;
        int w;
        rsp = '0; got = 0; viol = 0; first_cyc = -1; dropped = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (tx_start !== 1'b1 && w < budget) begin
                tick();
                w++;
            end
            if (tx_start !== 1'b1) return;
            if (i == 0) first_cyc = cyc;
            d = tx_data;
            rsp = {rsp[23:0], d};
            got++;
            tick();
            repeat ($urandom_range(0, 3)) begin
                if (tx_start !== 1'b0 || tx_data !== d) viol++;
                tick();
            end
            if (i == drop_at) begin
                rx_data = 8'($urandom);
                rx_done = 1'b1;
                #1;
                if (rx_dropped === 1'b1) dropped = 1'b1;
                tick();
                rx_done = 1'b0;
            end
            if (tx_start !== 1'b0 || tx_data !== d) viol++;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    task automatic do_frame(
        input logic [7:0] op, a, b, chk, input int drop_at,
        output logic [31:0] rsp, output int got, output int viol,
        output int lat, output bit dropped
    );
        int t0, fc;
        send_cmd(op, a, b, chk, t0);
        collect(4, 20, drop_at, rsp, got, viol, fc, dropped);
        lat = (fc < 0) ? -1 : fc - t0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({tx_start, busy, rx_dropped, tx_data, A, B, opcode} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ts=%b busy=%b drop=%b txd=%h A=%h B=%h op=%h, want all 0",
                     tx_start, busy, rx_dropped, tx_data, A, B, opcode);
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_spec_vectors();
        logic [31:0] rsp;
        int got, viol, lat;
        bit dr;
        do_frame(8'h01, 8'h05, 8'h03, 8'h07, -1, rsp, got, viol, lat, dr);
        n_vec++;
        if (rsp !== 32'h5A000808 || got !== 4 || viol !== 0) begin
            n_err++;
            $display("FAIL valid_frame: rsp=%h got=%0d viol=%0d want 5a000808/4/0", rsp, got, viol);
        end
        n_vec++;
        if ({A, B, opcode} !== {8'h05, 8'h03, 6'h01}) begin
            n_err++;
            $display("FAIL valid_operands: A=%h B=%h op=%h want 05 03 01", A, B, opcode);
        end
        n_vec++;
        if (lat !== ALU_LAT + 2) begin
            n_err++;
            $display("FAIL exec_latency: got %0d want %0d", lat, ALU_LAT + 2);
        end
        m_a = 8'h05; m_b = 8'h03; m_op = 6'h01;
        do_frame(8'h01, 8'h05, 8'h03, 8'h00, -1, rsp, got, viol, lat, dr);
        n_vec++;
        if (rsp !== 32'h5A010001 || got !== 4 || viol !== 0) begin
            n_err++;
            $display("FAIL bad_chk: rsp=%h got=%0d viol=%0d want 5a010001/4/0", rsp, got, viol);
        end
        do_frame(8'h41, 8'h07, 8'h09, 8'h47 ^ 8'h05 ^ 8'h03 ^ 8'h07 ^ 8'h09, -1,
                 rsp, got, viol, lat, dr);
        n_vec++;
        if (rsp !== 32'h5A020002 || got !== 4 || viol !== 0) begin
            n_err++;
            $display("FAIL bad_op: rsp=%h got=%0d viol=%0d want 5a020002/4/0", rsp, got, viol);
        end
        n_vec++;
        if ({A, B, opcode} !== {m_a, m_b, m_op}) begin
            n_err++;
            $display("FAIL error_hold: A=%h B=%h op=%h want %h %h %h", A, B, opcode, m_a, m_b, m_op);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rsp;
        int got, viol, fc, t0;
        bit dr;
        send_byte(8'hA5);
        send_byte(8'h01);
        t0 = cyc;
        send_byte(8'h05);
        collect(4, TMO + 20, -1, rsp, got, viol, fc, dr);
        n_vec++;
        if (rsp !== 32'h5A030003 || got !== 4 || viol !== 0) begin
            n_err++;
            $display("FAIL timeout_rsp: rsp=%h got=%0d viol=%0d want 5a030003/4/0", rsp, got, viol);
        end
        n_vec++;
        if (fc - t0 !== TMO + 1) begin
            n_err++;
            $display("FAIL timeout_delay: got %0d want %0d", fc - t0, TMO + 1);
        end
        n_vec++;
        if ({A, B, opcode} !== {m_a, m_b, m_op}) begin
            n_err++;
            $display("FAIL timeout_hold: A=%h B=%h op=%h want %h %h %h", A, B, opcode, m_a, m_b, m_op);
        end
        // Next byte lands exactly on the expiry cycle and must win
        send_byte(8'hA5);
        send_byte(8'h02);
        repeat (TMO - 1) tick();
        send_byte(8'h20);
        send_byte(8'h11);
        send_byte(8'h02 ^ 8'h20 ^ 8'h11);
        collect(4, 20, -1, rsp, got, viol, fc, dr);
        n_vec++;
        if (rsp !== 32'h5A003131 || got !== 4) begin
            n_err++;
            $display("FAIL timeout_edge: rsp=%h got=%0d want 5a003131/4", rsp, got);
        end
        m_a = 8'h20; m_b = 8'h11; m_op = 6'h02;
    endtask

    task automatic test_ignore_drop();
        logic [31:0] rsp, exp;
        logic [7:0] op, a, b;
        int got, viol, lat;
        bit dr, ok;
        send_byte(8'h11);
        tick();
        send_byte(8'h22);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignore: busy=%b want 0", busy);
        end
        op = 8'($urandom_range(0, 63));
        a = 8'($urandom);
        b = 8'($urandom);
        exp = model(op, a, b, op ^ a ^ b, 1'b0, ok);
        do_frame(op, a, b, op ^ a ^ b, 1, rsp, got, viol, lat, dr);
        n_vec++;
        if (rsp !== exp || got !== 4 || viol !== 0) begin
            n_err++;
            $display("FAIL drop_rsp: rsp=%h got=%0d viol=%0d want %h/4/0", rsp, got, viol, exp);
        end
        n_vec++;
        if (dr !== 1'b1) begin
            n_err++;
            $display("FAIL rx_dropped: pulse=%b want 1", dr);
        end
        m_a = a; m_b = b; m_op = op[OP_W-1:0];
    endtask

    task automatic test_random();
        logic [31:0] rsp, exp;
        logic [7:0] op, a, b, chk;
        int got, viol, lat, kind;
        bit dr, ok;
        for (int i = 0; i < 24; i++) begin
            op = 8'($urandom_range(0, 63));
            a = 8'($urandom);
            b = 8'($urandom);
            kind = $urandom_range(0, 2);
            if (kind == 2) op = op | 8'(1 << $urandom_range(OP_W, 7));
            chk = op ^ a ^ b;
            if (kind == 1) chk = chk ^ 8'($urandom_range(1, 255));
            exp = model(op, a, b, chk, 1'b0, ok);
            do_frame(op, a, b, chk, -1, rsp, got, viol, lat, dr);
            if (ok) begin
                m_a = a; m_b = b; m_op = op[OP_W-1:0];
            end
            n_vec++;
            if (rsp !== exp || got !== 4 || viol !== 0) begin
                n_err++;
                $display("FAIL random_rsp[%0d]: rsp=%h got=%0d viol=%0d want %h/4/0",
                         i, rsp, got, viol, exp);
            end
            n_vec++;
            if ({A, B, opcode} !== {m_a, m_b, m_op}) begin
                n_err++;
                $display("FAIL random_operands[%0d]: A=%h B=%h op=%h want %h %h %h",
                         i, A, B, opcode, m_a, m_b, m_op);
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] rsp, exp;
        int got, viol, fc, t0, w, starts;
        bit dr, ok;
        send_cmd(8'h03, 8'h40, 8'h02, 8'h41, t0);
        collect(2, 20, -1, rsp, got, viol, fc, dr);
        w = 0;
        while (tx_start !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_vec++;
        if (got !== 2 || tx_start !== 1'b1 || tx_data !== 8'h42) begin
            n_err++;
            $display("FAIL pre_reset_byte2: got=%0d ts=%b txd=%h want 2/1/42", got, tx_start, tx_data);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({tx_start, busy, rx_dropped, tx_data, A, B, opcode} !== '0) begin
            n_err++;
            $display("FAIL async_reset: ts=%b busy=%b txd=%h A=%h B=%h op=%h want all 0",
                     tx_start, busy, tx_data, A, B, opcode);
        end
        tick();
        tick();
        reset = 1'b1;
        m_a = '0; m_b = '0; m_op = '0;
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tx_done = (i % 5 == 2);
            tick();
            if (tx_start === 1'b1) starts++;
        end
        tx_done = 1'b0;
        n_vec++;
        if (starts !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_quiet: tx_starts=%0d busy=%b want 0/0", starts, busy);
        end
        exp = model(8'h3F, 8'hFF, 8'h02, 8'h3F ^ 8'hFF ^ 8'h02, 1'b0, ok);
        do_frame(8'h3F, 8'hFF, 8'h02, 8'h3F ^ 8'hFF ^ 8'h02, -1, rsp, got, viol, fc, dr);
        n_vec++;
        if (rsp !== exp || got !== 4 || viol !== 0) begin
            n_err++;
            $display("FAIL post_reset_frame: rsp=%h got=%0d viol=%0d want %h/4/0", rsp, got, viol, exp);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_timeout();
        test_ignore_drop();
        test_random();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
